uart_rx_param: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8-bit receive path. It takes an asynchronous `Serial_In` line in the system `Clk` domain and generates bit timing from a clock-cycles-per-bit counter, so no dedicated PLL clock is needed. It validates the start bit and supports configurable word length, optional parity and one or two stop bits. Each word is presented on `Parallel_Out` with a one-cycle `Flag_Rx` strobe and sticky-per-word error flags, for use by any UART consumer in the design.

---
 rtl/uart_rx_param_if.sv | 22 ++
 rtl/uart_rx_param.sv | 158 +++++++++++++++
 tb/tb_uart_rx_param.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Serial line plus received-word outputs of uart_rx_param.
// master is the receiver side; slave is the line driver / word consumer.
interface uart_rx_param_if #(
   parameter int WORD_LENGTH = 8
);
   logic                   Serial_In;
   logic [WORD_LENGTH-1:0] Parallel_Out;
   logic                   Flag_Rx;
   logic                   Parity_Error;
   logic                   Frame_Error;
   logic                   Busy;

   modport master (
      input  Serial_In,
      output Parallel_Out, Flag_Rx, Parity_Error, Frame_Error, Busy
   );

   modport slave (
      output Serial_In,
      input  Parallel_Out, Flag_Rx, Parity_Error, Frame_Error, Busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling from a cycles-per-bit counter,
// configurable word length, optional parity, one or two stop bits.
module uart_rx_param #(
   parameter int WORD_LENGTH  = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input logic             Clk,
   input logic             Reset,
   uart_rx_param_if.master rx
);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = 5;
   localparam bit ODD_SENSE = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic                   s1_reg, s2_reg, s3_reg;
   state_t                 state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [BW-1:0]          bit_reg, bit_next;
   logic [WORD_LENGTH-1:0] shift_reg, shift_next;
   logic                   par_err_reg, par_err_next;
   logic                   frm_err_reg, frm_err_next;
   logic                   done_reg, done_next;
   logic [WORD_LENGTH-1:0] word_reg;
   logic                   flag_reg, perr_out_reg, ferr_out_reg;
   logic                   fall, tick;

   assign fall = s3_reg & ~s2_reg;
   // START waits half a bit to land mid-start-bit; every later sample is a full bit apart.
   assign tick = (state_reg == S_START) ? (cnt_reg == CW'(H - 1))
                                        : (cnt_reg == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         s1_reg       <= 1'b1;
         s2_reg       <= 1'b1;
         s3_reg       <= 1'b1;
         state_reg    <= S_IDLE;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         par_err_reg  <= 1'b0;
         frm_err_reg  <= 1'b0;
         done_reg     <= 1'b0;
         word_reg     <= '0;
         flag_reg     <= 1'b0;
         perr_out_reg <= 1'b0;
         ferr_out_reg <= 1'b0;
      end else begin
         s1_reg      <= rx.Serial_In;
         s2_reg      <= s1_reg;
         s3_reg      <= s2_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         par_err_reg <= par_err_next;
         frm_err_reg <= frm_err_next;
         done_reg    <= done_next;
         flag_reg    <= done_reg;
         if (done_reg) begin
            word_reg     <= shift_reg;
            perr_out_reg <= par_err_reg;
            ferr_out_reg <= frm_err_reg;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      par_err_next = par_err_reg;
      frm_err_next = frm_err_reg;
      done_next    = 1'b0;

      if (state_reg == S_IDLE || state_reg == S_WAIT_HIGH) begin
         cnt_next = '0;
      end else begin
         cnt_next = tick ? '0 : cnt_reg + CW'(1);
      end

      case (state_reg)
         S_IDLE: begin
            bit_next = '0;
            if (fall) begin
               state_next   = S_START;
               par_err_next = 1'b0;
               frm_err_next = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               state_next = s2_reg ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_next = {s2_reg, shift_reg[WORD_LENGTH-1:1]};
               if (bit_reg == BW'(WORD_LENGTH - 1)) begin
                  bit_next   = '0;
                  state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_next = bit_reg + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               par_err_next = ((^shift_reg) ^ s2_reg) != ODD_SENSE;
               state_next   = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (!s2_reg) begin
                  frm_err_next = 1'b1;
               end
               if (bit_reg == BW'(STOP_BITS - 1)) begin
                  bit_next  = '0;
                  done_next = 1'b1;
                  // A low final stop bit means a break may be in progress; wait it out.
                  state_next = s2_reg ? S_IDLE : S_WAIT_HIGH;
               end else begin
                  bit_next = bit_reg + BW'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (s2_reg) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign rx.Parallel_Out = word_reg;
   assign rx.Flag_Rx      = flag_reg;
   assign rx.Parity_Error = perr_out_reg;
   assign rx.Frame_Error  = ferr_out_reg;
   assign rx.Busy         = (state_reg != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default 8N1 receiver and a 7-bit even-parity
// two-stop receiver, checked against a frame-level model of expected words and flag times.
module tb_uart_rx_param;
   localparam int WA = 8;
   localparam int CA = 16;
   localparam int WB = 7;
   localparam int CB = 8;
   localparam int ODD_B = 0;
   localparam int SB = 2;

   typedef struct {
      int          edge_n;
      logic [15:0] word;
      logic        pe;
      logic        fe;
   } rec_t;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int   edge_count = 0;
   int   checks = 0;
   int   errors = 0;
   rec_t obs_a[$], obs_b[$], exp_a[$], exp_b[$];
   rec_t last_a, last_b;

   always #5 Clk = ~Clk;
   always @(posedge Clk) edge_count <= edge_count + 1;

   uart_rx_param_if #(.WORD_LENGTH(WA)) if_a ();
   uart_rx_param_if #(.WORD_LENGTH(WB)) if_b ();

   uart_rx_param #(.WORD_LENGTH(WA), .CLKS_PER_BIT(CA), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(1))
      dut_a (.Clk(Clk), .Reset(Reset), .rx(if_a.master));

   uart_rx_param #(.WORD_LENGTH(WB), .CLKS_PER_BIT(CB), .PARITY_EN(1),
                   .PARITY_ODD(ODD_B), .STOP_BITS(SB))
      dut_b (.Clk(Clk), .Reset(Reset), .rx(if_b.master));

   // Values seen at a rising edge are those set by the previous edge, numbered edge_count.
   always @(posedge Clk) begin
      rec_t r;
      if (if_a.Flag_Rx === 1'b1) begin
         r.edge_n = edge_count; r.word = 16'(if_a.Parallel_Out);
         r.pe = if_a.Parity_Error; r.fe = if_a.Frame_Error;
         obs_a.push_back(r);
      end
      if (if_b.Flag_Rx === 1'b1) begin
         r.edge_n = edge_count; r.word = 16'(if_b.Parallel_Out);
         r.pe = if_b.Parity_Error; r.fe = if_b.Frame_Error;
         obs_b.push_back(r);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic rec_t zero_rec();
      rec_t r;
      r.edge_n = 0; r.word = '0; r.pe = 1'b0; r.fe = 1'b0;
      return r;
   endfunction

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) if_a.Serial_In = v;
      else          if_b.Serial_In = v;
   endtask

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? if_a.Busy : if_b.Busy;
   endfunction

   function automatic logic xor_bits(input logic [15:0] d, input int w);
      logic x = 1'b0;
      for (int i = 0; i < w; i++) x = x ^ d[i];
      return x;
   endfunction

   // Drives one frame bit by bit and records what the receiver must report for it.
   task automatic send(input int sel, input logic [15:0] data, input logic pbit,
                       input logic [1:0] stops, input int gap, input bit chk_busy);
      int   w, c, pe, sb, n, t0;
      logic bits[$];
      rec_t r;
      w  = (sel == 0) ? WA : WB;
      c  = (sel == 0) ? CA : CB;
      pe = (sel == 0) ? 0 : 1;
      sb = (sel == 0) ? 1 : SB;
      bits.push_back(1'b0);
      for (int i = 0; i < w; i++) bits.push_back(data[i]);
      if (pe != 0) bits.push_back(pbit);
      for (int i = 0; i < sb; i++) bits.push_back(stops[i]);
      n  = w + pe + sb;
      t0 = edge_count + 1;
      for (int b = 0; b < bits.size(); b++) begin
         set_line(sel, bits[b]);
         for (int j = 0; j < c; j++) begin
            @(negedge Clk);
            if (chk_busy && b == 0 && j == 1) check("busy_before_t0+2", 32'(get_busy(sel)), 32'd0);
            if (chk_busy && b == 0 && j == 2) check("busy_at_t0+2", 32'(get_busy(sel)), 32'd1);
         end
      end
      r.edge_n = t0 + 3 + c / 2 + n * c;
      r.word   = data & ((16'd1 << w) - 16'd1);
      r.pe     = (pe != 0) ? ((xor_bits(data, w) ^ pbit) != (ODD_B != 0)) : 1'b0;
      r.fe     = 1'b0;
      for (int i = 0; i < sb; i++) if (stops[i] == 1'b0) r.fe = 1'b1;
      if (sel == 0) begin exp_a.push_back(r); last_a = r; end
      else          begin exp_b.push_back(r); last_b = r; end
      if (gap > 0) begin
         set_line(sel, 1'b1);
         repeat (gap) @(negedge Clk);
      end
   endtask

   task automatic compare(input int sel, input string tag);
      rec_t oq[$], eq[$], o, e, l;
      logic [15:0] cur_w;
      logic cur_f, cur_pe, cur_fe;
      if (sel == 0) begin
         oq = obs_a; eq = exp_a; obs_a.delete(); exp_a.delete(); l = last_a;
         cur_w = 16'(if_a.Parallel_Out); cur_f = if_a.Flag_Rx;
         cur_pe = if_a.Parity_Error; cur_fe = if_a.Frame_Error;
      end else begin
         oq = obs_b; eq = exp_b; obs_b.delete(); exp_b.delete(); l = last_b;
         cur_w = 16'(if_b.Parallel_Out); cur_f = if_b.Flag_Rx;
         cur_pe = if_b.Parity_Error; cur_fe = if_b.Frame_Error;
      end
      check({tag, "_flag_count"}, 32'(oq.size()), 32'(eq.size()));
      while (oq.size() > 0 && eq.size() > 0) begin
         o = oq.pop_front();
         e = eq.pop_front();
         check({tag, "_flag_edge"}, 32'(o.edge_n), 32'(e.edge_n));
         check({tag, "_word"}, 32'(o.word), 32'(e.word));
         check({tag, "_parity_err"}, 32'(o.pe), 32'(e.pe));
         check({tag, "_frame_err"}, 32'(o.fe), 32'(e.fe));
      end
      check({tag, "_held_word"}, 32'(cur_w), 32'(l.word));
      check({tag, "_held_perr"}, 32'(cur_pe), 32'(l.pe));
      check({tag, "_held_ferr"}, 32'(cur_fe), 32'(l.fe));
      check({tag, "_flag_idle"}, 32'(cur_f), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_word"}, 32'(if_a.Parallel_Out), 32'd0);
      check({tag, "_a_flag"}, 32'(if_a.Flag_Rx), 32'd0);
      check({tag, "_a_perr"}, 32'(if_a.Parity_Error), 32'd0);
      check({tag, "_a_ferr"}, 32'(if_a.Frame_Error), 32'd0);
      check({tag, "_a_busy"}, 32'(if_a.Busy), 32'd0);
      check({tag, "_b_word"}, 32'(if_b.Parallel_Out), 32'd0);
      check({tag, "_b_busy"}, 32'(if_b.Busy), 32'd0);
   endtask

   initial begin
      logic [15:0] d;
      logic [1:0]  st;
      logic        pb;
      int          gap;
      if_a.Serial_In = 1'b1;
      if_b.Serial_In = 1'b1;
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      check_all_zero("reset");
      Reset = 1'b1;
      last_a = zero_rec();
      last_b = zero_rec();
      repeat (4) @(negedge Clk);

      // Basic 8N1 receive of 0xA5
      send(0, 16'hA5, 1'b0, 2'b11, 20, 1'b1);
      compare(0, "basic");

      // False start: low for 3 cycles only
      set_line(0, 1'b0);
      repeat (3) @(negedge Clk);
      check("false_start_busy", 32'(if_a.Busy), 32'd1);
      set_line(0, 1'b1);
      repeat (CA / 2 - 1) @(negedge Clk);
      check("false_start_busy_late", 32'(if_a.Busy), 32'd1);
      @(negedge Clk);
      check("false_start_idle", 32'(if_a.Busy), 32'd0);
      repeat (2 * 10 * CA) @(negedge Clk);
      compare(0, "false_start");

      // Back-to-back 0x00 then 0xFF
      send(0, 16'h00, 1'b0, 2'b11, 0, 1'b1);
      send(0, 16'hFF, 1'b0, 2'b11, 20, 1'b0);
      if (obs_a.size() >= 2) check("b2b_spacing", 32'(obs_a[1].edge_n - obs_a[0].edge_n), 32'd160);
      else                   check("b2b_two_flags", 32'(obs_a.size()), 32'd2);
      compare(0, "b2b");

      // Frame error followed by a 40-bit break, then a clean frame
      send(0, 16'h55, 1'b0, 2'b00, 0, 1'b0);
      repeat (40 * CA) @(negedge Clk);
      set_line(0, 1'b1);
      repeat (2 * CA) @(negedge Clk);
      compare(0, "break");
      send(0, 16'h12, 1'b0, 2'b11, 20, 1'b1);
      compare(0, "after_break");

      // Parity error then parity recovered (7E2 receiver)
      send(1, 16'h03, 1'b1, 2'b11, 20, 1'b1);
      compare(1, "parity_bad");
      send(1, 16'h07, 1'b1, 2'b11, 20, 1'b0);
      compare(1, "parity_ok");

      // Randomised frames on both receivers
      for (int k = 0; k < 8; k++) begin
         d   = 16'($urandom_range(0, 255));
         st  = ($urandom_range(0, 5) == 0) ? 2'b00 : 2'b11;
         gap = (st[0] == 1'b0) ? CA + int'($urandom_range(0, 12)) : int'($urandom_range(0, 12));
         send(0, d, 1'b0, st, gap, 1'b0);
      end
      repeat (2 * CA) @(negedge Clk);
      compare(0, "rand_a");
      for (int k = 0; k < 8; k++) begin
         d   = 16'($urandom_range(0, 127));
         pb  = xor_bits(d, WB) ^ 1'($urandom_range(0, 1));
         st  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) st = 2'b11;
         gap = (st[1] == 1'b0) ? CB + int'($urandom_range(0, 8)) : int'($urandom_range(0, 8));
         send(1, d, pb, st, gap, 1'b0);
      end
      repeat (2 * CB) @(negedge Clk);
      compare(1, "rand_b");

      // Reset pulse during data bit 4, then a full frame
      d = 16'h5A;
      set_line(0, 1'b0);
      repeat (CA) @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
         set_line(0, d[i]);
         repeat (CA) @(negedge Clk);
      end
      set_line(0, d[4]);
      repeat (CA / 2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check_all_zero("reset_mid");
      Reset = 1'b1;
      set_line(0, 1'b1);
      last_a = zero_rec();
      last_b = zero_rec();
      repeat (2 * 10 * CA) @(negedge Clk);
      compare(0, "reset_mid_a");
      compare(1, "reset_mid_b");
      send(0, 16'h3C, 1'b0, 2'b11, 20, 1'b1);
      compare(0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
